// File: rtl/chess_pkg.sv
// ============================================================================
// Module : chess_pkg
// Brief  : Piece/colour codes, FSM state encoding and back-rank pattern.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package chess_pkg;

    typedef enum logic {
        WHITE = 1'b0,
        BLACK = 1'b1
    } colour_e;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        KING   = 3'd1,
        QUEEN  = 3'd2,
        BISHOP = 3'd3,
        KNIGHT = 3'd4,
        ROOK   = 3'd5,
        PAWN   = 3'd6
    } piece_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        FETCH  = 3'd2,
        COMMIT = 3'd3,
        RESP   = 3'd4
    } state_e;

    // Back rank repeats R N B Q K B N R for boards wider than eight columns.
    function automatic piece_e back_rank(input int unsigned col);
        case (col % 8)
            0, 7:    return ROOK;
            1, 6:    return KNIGHT;
            2, 5:    return BISHOP;
            3:       return QUEEN;
            default: return KING;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/board_layout_gen.sv
// ============================================================================
// Module : board_layout_gen
// Brief  : Combinational start-position image, square i = col*ROWS + row.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module board_layout_gen
    import chess_pkg::*;
#(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int PIECE_W = 4
) (
    output logic [ROWS*COLS*PIECE_W-1:0] board
);

    for (genvar i = 0; i < ROWS*COLS; i++) begin : g_sq
        localparam int c_ROW = i % ROWS;
        localparam int c_COL = i / ROWS;

        logic [PIECE_W-1:0] w_pc;

        always_comb begin
            w_pc = '0;
            if (c_ROW == 0) begin
                w_pc[PIECE_W-1] = BLACK;
                w_pc[2:0]       = back_rank(c_COL);
            end else if (c_ROW == 1) begin
                w_pc[PIECE_W-1] = BLACK;
                w_pc[2:0]       = PAWN;
            end else if (c_ROW == ROWS-2) begin
                w_pc[PIECE_W-1] = WHITE;
                w_pc[2:0]       = PAWN;
            end else if (c_ROW == ROWS-1) begin
                w_pc[PIECE_W-1] = WHITE;
                w_pc[2:0]       = back_rank(c_COL);
            end
        end

        assign board[i*PIECE_W +: PIECE_W] = w_pc;
    end

endmodule

`default_nettype wire

// File: rtl/board_store.sv
// ============================================================================
// Module : board_store
// Brief  : Board register file with validated move/capture/promotion FSM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module board_store
    import chess_pkg::*;
#(
    parameter  int ROWS    = 8,
    parameter  int COLS    = 8,
    parameter  int PIECE_W = 4,
    localparam int N       = ROWS*COLS,
    localparam int SQ_W    = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_req,
    input  logic                   mv_valid,
    output logic                   mv_ready,
    input  logic [SQ_W-1:0]        mv_src,
    input  logic [SQ_W-1:0]        mv_dst,
    input  logic [2:0]             mv_promo,
    output logic                   done,
    output logic                   err,
    output logic [PIECE_W-1:0]     captured,
    output logic                   busy,
    output logic [N*PIECE_W-1:0]   board
);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [N*PIECE_W-1:0]   r_board;
    logic [N*PIECE_W-1:0]   w_start;
    logic [SQ_W-1:0]        r_src;
    logic [SQ_W-1:0]        r_dst;
    logic [2:0]             r_promo;
    logic                   r_err;
    logic [PIECE_W-1:0]     r_captured;

    logic [31:0]            w_src_i;
    logic [31:0]            w_dst_i;
    logic [31:0]            w_dst_row;
    logic                   w_src_ok;
    logic                   w_dst_ok;
    logic [PIECE_W-1:0]     w_src_pc;
    logic [PIECE_W-1:0]     w_dst_pc;
    logic [PIECE_W-1:0]     w_moved;
    logic [PIECE_W-1:0]     w_empty_pc;
    logic                   w_err;
    logic                   w_promo_ok;

    board_layout_gen #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .PIECE_W (PIECE_W)
    ) u_layout (
        .board (w_start)
    );

    // Square reads are gated so an out-of-range index never selects board bits.
    always_comb begin
        w_src_i    = 32'(r_src);
        w_dst_i    = 32'(r_dst);
        w_dst_row  = w_dst_i % 32'(ROWS);
        w_src_ok   = w_src_i < 32'(N);
        w_dst_ok   = w_dst_i < 32'(N);
        w_src_pc   = w_src_ok ? r_board[w_src_i*PIECE_W +: PIECE_W] : '0;
        w_dst_pc   = w_dst_ok ? r_board[w_dst_i*PIECE_W +: PIECE_W] : '0;
        w_empty_pc = '0;
        w_empty_pc[PIECE_W-1] = WHITE;
        w_err = !w_src_ok || !w_dst_ok || (r_src == r_dst) ||
                (w_src_pc[2:0] == EMPTY) ||
                ((w_dst_pc[2:0] != EMPTY) &&
                 (w_dst_pc[PIECE_W-1] == w_src_pc[PIECE_W-1]));
        w_promo_ok = (r_promo == QUEEN) || (r_promo == BISHOP) ||
                     (r_promo == KNIGHT) || (r_promo == ROOK);
        w_moved = w_src_pc;
        if ((w_src_pc[2:0] == PAWN) && w_promo_ok &&
            ((w_dst_row == 32'd0) || (w_dst_row == 32'(ROWS-1)))) begin
            w_moved[2:0] = r_promo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        mv_ready    = (r_state == IDLE) && !init_req;
        case (r_state)
            IDLE: begin
                if (init_req)      w_state_nxt = INIT;
                else if (mv_valid) w_state_nxt = FETCH;
            end
            INIT:    w_state_nxt = IDLE;
            FETCH:   w_state_nxt = w_err ? RESP : COMMIT;
            COMMIT:  w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_board    <= w_start;
            r_src      <= '0;
            r_dst      <= '0;
            r_promo    <= '0;
            r_err      <= 1'b0;
            r_captured <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mv_valid && mv_ready) begin
                        r_src   <= mv_src;
                        r_dst   <= mv_dst;
                        r_promo <= mv_promo;
                    end
                end
                INIT: r_board <= w_start;
                FETCH: begin
                    r_err <= w_err;
                    if (w_err) r_captured <= '0;
                end
                COMMIT: begin
                    // src != dst is guaranteed here, so the two writes never collide.
                    r_board[w_dst_i*PIECE_W +: PIECE_W] <= w_moved;
                    r_board[w_src_i*PIECE_W +: PIECE_W] <= w_empty_pc;
                    r_captured                          <= w_dst_pc;
                end
                default: ;
            endcase
        end
    end

    assign done     = (r_state == RESP);
    assign err      = done && r_err;
    assign captured = r_captured;
    assign busy     = (r_state != IDLE);
    assign board    = r_board;

endmodule

`default_nettype wire

// File: tb/tb_board_store.sv
// ============================================================================
// Module : tb_board_store
// Brief  : Directed self-checking bench for board_store on an 8x8 board.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_board_store;

    localparam int ROWS    = 8;
    localparam int COLS    = 8;
    localparam int PIECE_W = 4;
    localparam int N       = ROWS*COLS;
    localparam int SQ_W    = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 init_req = 1'b0;
    logic                 mv_valid = 1'b0;
    logic                 mv_ready;
    logic [SQ_W-1:0]      mv_src = '0;
    logic [SQ_W-1:0]      mv_dst = '0;
    logic [2:0]           mv_promo = '0;
    logic                 done;
    logic                 err;
    logic [PIECE_W-1:0]   captured;
    logic                 busy;
    logic [N*PIECE_W-1:0] board;

    int n_cmp = 0;
    int n_bad = 0;

    board_store #(.ROWS(ROWS), .COLS(COLS), .PIECE_W(PIECE_W)) dut (
        .clk(clk), .rst(rst), .init_req(init_req), .mv_valid(mv_valid),
        .mv_ready(mv_ready), .mv_src(mv_src), .mv_dst(mv_dst),
        .mv_promo(mv_promo), .done(done), .err(err), .captured(captured),
        .busy(busy), .board(board)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N*PIECE_W-1:0] got,
                         input logic [N*PIECE_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] sq(input logic [N*PIECE_W-1:0] b, input int i);
        return b[i*4 +: 4];
    endfunction

    function automatic logic [N*PIECE_W-1:0] put(input logic [N*PIECE_W-1:0] b,
                                                  input int i, input logic [3:0] v);
        logic [N*PIECE_W-1:0] t;
        t = b;
        t[i*4 +: 4] = v;
        return t;
    endfunction

    // Hand-written start position: black back rank row 0, white back rank row 7.
    function automatic logic [N*PIECE_W-1:0] start_pos();
        logic [2:0] pat [8];
        logic [N*PIECE_W-1:0] b;
        pat = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd3, 3'd4, 3'd5};
        b = '0;
        for (int c = 0; c < 8; c++) begin
            b = put(b, c*8 + 0, {1'b1, pat[c]});
            b = put(b, c*8 + 1, 4'b1110);
            b = put(b, c*8 + 6, 4'b0110);
            b = put(b, c*8 + 7, {1'b0, pat[c]});
        end
        return b;
    endfunction

    // Issues one move from IDLE; lat counts edges from the handshake edge to done.
    task automatic do_move(input int s, input int d, input int p, output int lat,
                           output logic e, output logic [3:0] cap);
        mv_src   = 6'(s);
        mv_dst   = 6'(d);
        mv_promo = 3'(p);
        mv_valid = 1'b1;
        lat = 0;
        e   = 1'b0;
        cap = '0;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) mv_valid = 1'b0;
            if (done) begin
                e   = err;
                cap = captured;
                break;
            end
        end
    endtask

    logic [N*PIECE_W-1:0] exp_b;
    logic [N*PIECE_W-1:0] start_b;
    int         lat;
    logic       e;
    logic [3:0] cap;
    logic       saw_done;

    initial begin
        start_b = start_pos();
        exp_b   = start_b;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", mv_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_cap", captured, 4'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_sq0", sq(board, 0), 4'b1101);
        check("rst_sq7", sq(board, 7), 4'b0101);
        check("rst_sq38", sq(board, 38), 4'b0110);
        check("rst_sq36", sq(board, 36), 4'b0000);
        check("rst_board", board, start_b);

        // Quiet white pawn advance.
        do_move(38, 36, 0, lat, e, cap);
        check("m1_lat", lat, 3);
        check("m1_err", e, 1'b0);
        check("m1_cap", cap, 4'd0);
        exp_b = put(put(exp_b, 38, 4'b0000), 36, 4'b0110);
        check("m1_board", board, exp_b);
        @(posedge clk); #1;
        check("m1_done_pulse", done, 1'b0);
        check("m1_cap_hold", captured, 4'd0);
        check("m1_ready", mv_ready, 1'b1);

        // Empty source is rejected; board must not change.
        do_move(10, 11, 0, lat, e, cap);
        check("m2_lat", (lat == 2 || lat == 3), 1'b1);
        check("m2_err", e, 1'b1);
        check("m2_cap", cap, 4'd0);
        check("m2_board", board, exp_b);
        @(posedge clk); #1;
        check("m2_err_clear", err, 1'b0);

        // Same-colour destination.
        do_move(7, 6, 0, lat, e, cap);
        check("m3_err", e, 1'b1);
        check("m3_board", board, exp_b);
        @(posedge clk); #1;

        // src == dst.
        do_move(0, 0, 0, lat, e, cap);
        check("m4_err", e, 1'b1);
        check("m4_board", board, exp_b);
        @(posedge clk); #1;

        // Black pawn captures white pawn.
        do_move(1, 6, 0, lat, e, cap);
        check("m5_err", e, 1'b0);
        check("m5_cap", cap, 4'b0110);
        check("m5_sq6", sq(board, 6), 4'b1110);
        check("m5_sq1", sq(board, 1), 4'b0000);
        exp_b = put(put(exp_b, 1, 4'b0000), 6, 4'b1110);
        check("m5_board", board, exp_b);
        @(posedge clk); #1;
        check("m5_cap_hold", captured, 4'b0110);

        // Capture onto white back rank with queen promotion.
        do_move(6, 7, 2, lat, e, cap);
        check("m6_err", e, 1'b0);
        check("m6_cap", cap, 4'b0101);
        check("m6_sq7", sq(board, 7), 4'b1010);
        exp_b = put(put(exp_b, 6, 4'b0000), 7, 4'b1010);
        check("m6_board", board, exp_b);
        @(posedge clk); #1;

        // Reset while the move sits in FETCH: abandoned, start position restored.
        mv_src = 6'd22; mv_dst = 6'd21; mv_promo = 3'd0; mv_valid = 1'b1;
        @(posedge clk); #1;
        mv_valid = 1'b0;
        check("rf_fetch_busy", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rf_done_in_rst", done, 1'b0);
        rst = 1'b0;
        saw_done = 1'b0;
        @(posedge clk); #1;
        saw_done = saw_done | done;
        check("rf_ready", mv_ready, 1'b1);
        check("rf_board", board, start_b);
        @(posedge clk); #1;
        saw_done = saw_done | done;
        check("rf_no_done", saw_done, 1'b0);
        exp_b = start_b;

        // Promotion code ignored off the last rank.
        do_move(14, 13, 2, lat, e, cap);
        check("m7_err", e, 1'b0);
        check("m7_sq13", sq(board, 13), 4'b0110);
        exp_b = put(put(exp_b, 14, 4'b0000), 13, 4'b0110);
        check("m7_board", board, exp_b);
        @(posedge clk); #1;

        // init_req wins over a simultaneous move request.
        init_req = 1'b1; mv_valid = 1'b1; mv_src = 6'd22; mv_dst = 6'd21;
        #1;
        check("in_ready", mv_ready, 1'b0);
        @(posedge clk); #1;
        init_req = 1'b0; mv_valid = 1'b0;
        check("in_busy", busy, 1'b1);
        check("in_done1", done, 1'b0);
        @(posedge clk); #1;
        check("in_idle", busy, 1'b0);
        check("in_done2", done, 1'b0);
        check("in_board", board, start_b);
        @(posedge clk); #1;
        check("in_done3", done, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
